// File: rtl/decoder_scan_nx_if.sv
// Control/status bundle for decoder_scan_nx; master drives select/scan controls, slave returns the decode.
// Parameters must match the decoder instance they connect to.
interface decoder_scan_nx_if #(
  parameter int SEL_W   = 3,
  parameter int OUT_N   = 8,
  parameter int DWELL_W = 8
);
  logic               en;
  logic               mode;
  logic               load;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_N-1:0]   d;
  logic [SEL_W-1:0]   idx;
  logic               wrap;
  logic               err;

  modport master (
    output en, mode, load, sel, dwell,
    input  d, idx, wrap, err
  );

  modport slave (
    input  en, mode, load, sel, dwell,
    output d, idx, wrap, err
  );
endinterface

// File: rtl/decoder_scan_nx.sv
// Registered one-hot decoder with direct load and auto-scan; load-to-d latency 1 cycle, no backpressure.
// Define DECODER_SCAN_BLANK_EN to blank d for one cycle on every scan advance.
module decoder_scan_nx #(
  parameter int SEL_W   = 3,
  parameter int OUT_N   = 8,
  parameter int DWELL_W = 8
) (
  input logic              clk,
  input logic              rst,
  decoder_scan_nx_if.slave bus
);

`ifdef DECODER_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_N - 1);

  logic [SEL_W-1:0]   idx_q, idx_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic               mode_q, mode_n;
  logic [OUT_N-1:0]   d_q, d_n;
  logic               wrap_q, wrap_n;
  logic               err_q, err_n;
  logic               load_ok;
  logic               advance;

  function automatic logic [OUT_N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_N-1:0] v;
    v = '0;
    for (int k = 0; k < OUT_N; k++) begin
      if (i == SEL_W'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    load_ok = bus.load && (32'(bus.sel) < 32'(OUT_N));
    advance = 1'b0;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    mode_n  = mode_q;
    wrap_n  = 1'b0;
    err_n   = bus.load && !load_ok;

    if (bus.en) mode_n = bus.mode;

    // Any load, valid or not, suppresses the scan step for this cycle.
    if (load_ok) begin
      idx_n = bus.sel;
      cnt_n = '0;
    end else if (!bus.load && bus.en) begin
      if ((bus.mode != mode_q) || !mode_q) begin
        cnt_n = '0;
      end else if (cnt_q == bus.dwell) begin
        cnt_n   = '0;
        advance = 1'b1;
        if (idx_q == LAST) begin
          idx_n  = '0;
          wrap_n = 1'b1;
        end else begin
          idx_n = idx_q + SEL_W'(1);
        end
      end else begin
        // Free-running wrap at 2**DWELL_W-1 is how a lowered dwell eventually takes effect.
        cnt_n = cnt_q + DWELL_W'(1);
      end
    end

    d_n = (bus.en && !(BLANK && advance)) ? onehot(idx_n) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      d_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_n;
      cnt_q  <= cnt_n;
      mode_q <= mode_n;
      d_q    <= d_n;
      wrap_q <= wrap_n;
      err_q  <= err_n;
    end
  end

  assign bus.d    = d_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;

  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.d));
  a_idx_rng: assert property (@(posedge clk) disable iff (rst) 32'(bus.idx) < 32'(OUT_N));

endmodule
